// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel queue: entry field widths, entry layout
// and the clear-sequencer state encoding.
package vga_pkg;

  localparam int unsigned XWidth     = 8;
  localparam int unsigned YWidth     = 7;
  localparam int unsigned ColorWidth = 3;
  localparam int unsigned EntryWidth = XWidth + YWidth + ColorWidth;  // 18 bits

  // One queued pixel, packed {x, y, color}.
  typedef struct packed {
    logic [XWidth-1:0]     x;
    logic [YWidth-1:0]     y;
    logic [ColorWidth-1:0] color;
  } pixel_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClear = 2'd1,
    StAck   = 2'd2
  } state_e;

endpackage

// File: rtl/pixel_fifo.sv
// Pixel storage: circular buffer with read/write pointers and an occupancy count.
// Read data is combinational from the head entry; the caller only pops when non-empty
// and only pushes when not full (or when popping in the same cycle).
module pixel_fifo
  import vga_pkg::*;
#(
  parameter int unsigned Depth = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [EntryWidth-1:0] i_wr_data,
  input  logic                  i_pop,
  output logic [EntryWidth-1:0] o_rd_data,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int unsigned PtrWidth = $clog2(Depth);
  localparam logic [PtrWidth:0] FullCount = (PtrWidth + 1)'(Depth);

  logic [EntryWidth-1:0] r_mem [Depth];
  logic [PtrWidth-1:0]   r_wr_ptr;
  logic [PtrWidth-1:0]   r_rd_ptr;
  logic [PtrWidth:0]     r_count;

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !i_pop)      r_count <= r_count + 1'b1;
      else if (!i_push && i_pop) r_count <= r_count - 1'b1;
    end
  end

  // Storage array; contents are discarded on reset by clearing the pointers.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = (r_count == FullCount);
  assign o_empty   = (r_count == '0);

endmodule

// File: rtl/vga_pixel_queue.sv
// Pixel queue between drawing engines and the VGA adapter. Range-checks pushes,
// buffers them in pixel_fifo, pops one per cycle through a stage register into the
// registered VGA drive (two-edge push-to-plot latency).
// Optional screen-clear sweep enabled by defining VGA_CLEAR_SCREEN_EN; without it
// the queue stays idle and clearAck simply mirrors clearReq.
module vga_pixel_queue
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned X_MAX       = 159,
  parameter int unsigned Y_MAX       = 119,
  parameter logic [2:0]  CLEAR_COLOR = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       resetIn,
  input  logic       pixWrite,
  input  logic [7:0] pixX,
  input  logic [6:0] pixY,
  input  logic [2:0] pixColor,
  output logic       full,
  output logic       overflow,
  input  logic       clearReq,
  output logic       clearAck,
  output logic [7:0] vgaX,
  output logic [6:0] vgaY,
  output logic [2:0] vgaColor,
  output logic       vgaPlot
);

  localparam logic [XWidth-1:0] XMax = XWidth'(X_MAX);
  localparam logic [YWidth-1:0] YMax = YWidth'(Y_MAX);

  logic                  w_in_range;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop_allowed;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_clr_write;
  logic [XWidth-1:0]     w_clr_x;
  logic [YWidth-1:0]     w_clr_y;
  logic [EntryWidth-1:0] w_rd_data;
  pixel_t                w_push_pix;
  pixel_t                w_pop_pix;
  pixel_t                w_clr_pix;

  logic                  r_overflow;
  logic                  r_stg_valid;
  pixel_t                r_stg_pix;
  logic                  r_vga_plot;
  pixel_t                r_vga_pix;

  assign w_in_range = (pixX <= XMax) && (pixY <= YMax);
  assign w_push_pix = '{x: pixX, y: pixY, color: pixColor};
  assign w_pop_pix  = pixel_t'(w_rd_data);
  assign w_pop      = !w_empty && w_pop_allowed;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_push     = pixWrite && w_in_range && (!w_full || w_pop);
  assign w_drop     = pixWrite && w_in_range && w_full && !w_pop;
  assign w_clr_pix  = '{x: w_clr_x, y: w_clr_y, color: CLEAR_COLOR};

  pixel_fifo #(
    .Depth(DEPTH)
  ) u_pixel_fifo (
    .i_clk    (CLOCK_50),
    .i_rst_n  (resetIn),
    .i_push   (w_push),
    .i_wr_data(w_push_pix),
    .i_pop    (w_pop),
    .o_rd_data(w_rd_data),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

`ifdef VGA_CLEAR_SCREEN_EN
  state_e            r_state;
  state_e            w_state_d;
  logic [XWidth-1:0] r_clr_x;
  logic [XWidth-1:0] w_clr_x_d;
  logic [YWidth-1:0] r_clr_y;
  logic [YWidth-1:0] w_clr_y_d;

  // Clear sequencer state and raster counters.
  always_ff @(posedge CLOCK_50) begin
    if (!resetIn) begin
      r_state <= StIdle;
      r_clr_x <= '0;
      r_clr_y <= '0;
    end else begin
      r_state <= w_state_d;
      r_clr_x <= w_clr_x_d;
      r_clr_y <= w_clr_y_d;
    end
  end

  // Next state: clear starts only once drained, sweeps x-major, then waits for
  // clearReq to drop. clearReq is not looked at during the sweep.
  always_comb begin
    w_state_d   = r_state;
    w_clr_x_d   = r_clr_x;
    w_clr_y_d   = r_clr_y;
    w_clr_write = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (clearReq && w_empty) w_state_d = StClear;
      end
      StClear: begin
        w_clr_write = 1'b1;
        if (r_clr_x == XMax) begin
          w_clr_x_d = '0;
          if (r_clr_y == YMax) begin
            w_clr_y_d = '0;
            w_state_d = StAck;
          end else begin
            w_clr_y_d = r_clr_y + 1'b1;
          end
        end else begin
          w_clr_x_d = r_clr_x + 1'b1;
        end
      end
      StAck: begin
        if (!clearReq) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_pop_allowed = (r_state == StIdle) || (r_state == StAck);
  assign w_clr_x       = r_clr_x;
  assign w_clr_y       = r_clr_y;
  assign clearAck      = (r_state == StAck);
`else
  assign w_pop_allowed = 1'b1;
  assign w_clr_write   = 1'b0;
  assign w_clr_x       = '0;
  assign w_clr_y       = '0;
  assign clearAck      = clearReq;
`endif

  // Sticky overflow on any in-range push lost to a full queue.
  always_ff @(posedge CLOCK_50) begin
    if (!resetIn)    r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  // Pop/clear stage: pops and clear writes never coincide, so they share it.
  always_ff @(posedge CLOCK_50) begin
    if (!resetIn) begin
      r_stg_valid <= 1'b0;
      r_stg_pix   <= '0;
    end else begin
      r_stg_valid <= w_pop || w_clr_write;
      if (w_clr_write) r_stg_pix <= w_clr_pix;
      else if (w_pop)  r_stg_pix <= w_pop_pix;
    end
  end

  // Registered drive to the VGA adapter.
  always_ff @(posedge CLOCK_50) begin
    if (!resetIn) begin
      r_vga_plot <= 1'b0;
      r_vga_pix  <= '0;
    end else begin
      r_vga_plot <= r_stg_valid;
      if (r_stg_valid) r_vga_pix <= r_stg_pix;
    end
  end

  assign full     = w_full;
  assign overflow = r_overflow;
  assign vgaPlot  = r_vga_plot;
  assign vgaX     = r_vga_pix.x;
  assign vgaY     = r_vga_pix.y;
  assign vgaColor = r_vga_pix.color;

endmodule

// File: tb/tb_vga_pixel_queue.sv
// Directed bench for vga_pixel_queue. Clear-sweep scenarios are compiled in when
// VGA_CLEAR_SCREEN_EN is defined; otherwise the clearReq passthrough is exercised.
module tb_vga_pixel_queue;

  logic       CLOCK_50 = 1'b0;
  logic       resetIn  = 1'b0;
  logic       pixWrite = 1'b0;
  logic [7:0] pixX     = '0;
  logic [6:0] pixY     = '0;
  logic [2:0] pixColor = '0;
  logic       clearReq = 1'b0;
  logic       full;
  logic       overflow;
  logic       clearAck;
  logic [7:0] vgaX;
  logic [6:0] vgaY;
  logic [2:0] vgaColor;
  logic       vgaPlot;

  int checks = 0;
  int errors = 0;

  logic [7:0] bx [4];
  logic [6:0] by [4];
  logic [2:0] bc [4];

  vga_pixel_queue dut (
    .CLOCK_50(CLOCK_50),
    .resetIn (resetIn),
    .pixWrite(pixWrite),
    .pixX    (pixX),
    .pixY    (pixY),
    .pixColor(pixColor),
    .full    (full),
    .overflow(overflow),
    .clearReq(clearReq),
    .clearAck(clearAck),
    .vgaX    (vgaX),
    .vgaY    (vgaY),
    .vgaColor(vgaColor),
    .vgaPlot (vgaPlot)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset();
    resetIn = 1'b0; pixWrite = 1'b0; clearReq = 1'b0;
    repeat (3) tick();
    checks++; if (vgaPlot !== 1'b0) begin errors++; $display("FAIL reset_plot got %b want 0", vgaPlot); end
    checks++; if ({vgaX, vgaY, vgaColor} !== 18'h0) begin errors++;
      $display("FAIL reset_vga got %h want 0", {vgaX, vgaY, vgaColor}); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
    checks++; if (clearAck !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", clearAck); end
    resetIn = 1'b1;
    tick();
    checks++; if (vgaPlot !== 1'b0) begin errors++; $display("FAIL post_reset_plot got %b want 0", vgaPlot); end
  endtask

  // One pixel into an empty queue: plot appears after the second edge, for one cycle.
  task automatic test_single_push();
    pixWrite = 1'b1; pixX = 8'd10; pixY = 7'd20; pixColor = 3'b101;
    tick();
    pixWrite = 1'b0;
    checks++; if (vgaPlot !== 1'b0) begin errors++; $display("FAIL single_e0 got %b want 0", vgaPlot); end
    tick();
    checks++; if (vgaPlot !== 1'b0) begin errors++; $display("FAIL single_e1 got %b want 0", vgaPlot); end
    tick();
    checks++; if (vgaPlot !== 1'b1) begin errors++; $display("FAIL single_e2 got %b want 1", vgaPlot); end
    checks++; if ({vgaX, vgaY, vgaColor} !== {8'd10, 7'd20, 3'd5}) begin errors++;
      $display("FAIL single_data got %0d,%0d,%0d want 10,20,5", vgaX, vgaY, vgaColor); end
    tick();
    checks++; if (vgaPlot !== 1'b0) begin errors++; $display("FAIL single_e3 got %b want 0", vgaPlot); end
  endtask

  // Consecutive pushes, including the corner coordinates, come out in order.
  task automatic test_back_to_back();
    int got;
    bx[0] = 8'd0;   by[0] = 7'd0;   bc[0] = 3'd6;
    bx[1] = 8'd159; by[1] = 7'd119; bc[1] = 3'd7;
    bx[2] = 8'd33;  by[2] = 7'd64;  bc[2] = 3'd2;
    bx[3] = 8'd100; by[3] = 7'd1;   bc[3] = 3'd4;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        pixWrite = 1'b1; pixX = bx[i]; pixY = by[i]; pixColor = bc[i];
      end else begin
        pixWrite = 1'b0;
      end
      tick();
      if (vgaPlot === 1'b1) begin
        checks++;
        if (got >= 4) begin
          errors++; $display("FAIL b2b_extra got plot %0d want none", got);
        end else if ({vgaX, vgaY, vgaColor} !== {bx[got], by[got], bc[got]}) begin
          errors++; $display("FAIL b2b_data[%0d] got %0d,%0d,%0d want %0d,%0d,%0d", got,
                             vgaX, vgaY, vgaColor, bx[got], by[got], bc[got]);
        end
        got++;
      end
    end
    checks++; if (got != 4) begin errors++; $display("FAIL b2b_count got %0d want 4", got); end
  endtask

  task automatic test_out_of_range();
    int plots;
    plots = 0;
    for (int i = 0; i < 8; i++) begin
      pixWrite = (i < 3);
      unique case (i)
        0:       begin pixX = 8'd160; pixY = 7'd0;   pixColor = 3'd1; end
        1:       begin pixX = 8'd0;   pixY = 7'd120; pixColor = 3'd2; end
        default: begin pixX = 8'd255; pixY = 7'd127; pixColor = 3'd3; end
      endcase
      tick();
      if (vgaPlot === 1'b1) plots++;
    end
    pixWrite = 1'b0;
    checks++; if (plots != 0) begin errors++; $display("FAIL oor_plots got %0d want 0", plots); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL oor_ovf got %b want 0", overflow); end
  endtask

  // Reset with entries queued and in flight: everything is discarded.
  task automatic test_reset_flush();
    int plots;
    for (int i = 0; i < 3; i++) begin
      pixWrite = 1'b1; pixX = 8'(20 + i); pixY = 7'(30 + i); pixColor = 3'(i + 1);
      tick();
    end
    pixWrite = 1'b0; resetIn = 1'b0;
    tick();
    checks++; if (vgaPlot !== 1'b0) begin errors++; $display("FAIL flush_plot got %b want 0", vgaPlot); end
    checks++; if ({vgaX, vgaY, vgaColor} !== 18'h0) begin errors++;
      $display("FAIL flush_vga got %h want 0", {vgaX, vgaY, vgaColor}); end
    resetIn = 1'b1;
    plots = 0;
    repeat (6) begin tick(); if (vgaPlot === 1'b1) plots++; end
    checks++; if (plots != 0) begin errors++; $display("FAIL flush_plots got %0d want 0", plots); end
  endtask

`ifndef VGA_CLEAR_SCREEN_EN
  task automatic test_clear_disabled();
    int plots;
    plots = 0;
    clearReq = 1'b1;
    #1;
    checks++; if (clearAck !== 1'b1) begin errors++; $display("FAIL nc_ack_hi got %b want 1", clearAck); end
    repeat (6) begin tick(); if (vgaPlot === 1'b1) plots++; end
    checks++; if (clearAck !== 1'b1) begin errors++; $display("FAIL nc_ack_hold got %b want 1", clearAck); end
    clearReq = 1'b0;
    #1;
    checks++; if (clearAck !== 1'b0) begin errors++; $display("FAIL nc_ack_lo got %b want 0", clearAck); end
    repeat (4) begin tick(); if (vgaPlot === 1'b1) plots++; end
    checks++; if (plots != 0) begin errors++; $display("FAIL nc_plots got %0d want 0", plots); end
  endtask
`else
  task automatic test_clear_sweep();
    int plots, bad, ex, ey;
    logic [17:0] first_pix, last_pix;
    plots = 0; bad = 0; ex = 0; ey = 0; first_pix = '1; last_pix = '1;
    clearReq = 1'b1;
    for (int cyc = 0; cyc < 19300 && plots < 19200; cyc++) begin
      tick();
      if (vgaPlot === 1'b1) begin
        if (plots == 0) first_pix = {vgaX, vgaY, vgaColor};
        last_pix = {vgaX, vgaY, vgaColor};
        if ({vgaX, vgaY, vgaColor} !== {8'(ex), 7'(ey), 3'd0}) bad++;
        ex++; if (ex == 160) begin ex = 0; ey++; end
        plots++;
      end else if (plots > 0) begin
        bad++;
      end
    end
    checks++; if (plots != 19200) begin errors++; $display("FAIL sweep_count got %0d want 19200", plots); end
    checks++; if (bad != 0) begin errors++; $display("FAIL sweep_order got %0d bad want 0", bad); end
    checks++; if (first_pix !== 18'h0) begin errors++; $display("FAIL sweep_first got %h want 0", first_pix); end
    checks++; if (last_pix !== {8'd159, 7'd119, 3'd0}) begin errors++;
      $display("FAIL sweep_last got %h want %h", last_pix, {8'd159, 7'd119, 3'd0}); end
    repeat (3) tick();
    checks++; if (vgaPlot !== 1'b0) begin errors++; $display("FAIL sweep_after got %b want 0", vgaPlot); end
    checks++; if (clearAck !== 1'b1) begin errors++; $display("FAIL sweep_ack got %b want 1", clearAck); end
    clearReq = 1'b0;
    tick();
    checks++; if (clearAck !== 1'b0) begin errors++; $display("FAIL sweep_ack_lo got %b want 0", clearAck); end
  endtask

  // 17 pushes while the sweep holds pops off; clearReq drops mid-sweep and is ignored.
  task automatic test_overflow();
    int plots, bad, ex, ey, k;
    plots = 0; bad = 0; ex = 0; ey = 0;
    for (int cyc = 0; cyc < 19400; cyc++) begin
      clearReq = (cyc < 100);
      if (cyc >= 5 && cyc < 22) begin
        pixWrite = 1'b1; pixX = 8'(cyc - 4); pixY = 7'(cyc - 3); pixColor = 3'(((cyc - 5) % 7) + 1);
      end else begin
        pixWrite = 1'b0;
      end
      tick();
      if (cyc == 20) begin
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full16 got %b want 1", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre got %b want 0", overflow); end
      end
      if (cyc == 21) begin
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
      end
      if (vgaPlot === 1'b1) begin
        if (plots < 19200) begin
          if ({vgaX, vgaY, vgaColor} !== {8'(ex), 7'(ey), 3'd0}) bad++;
          ex++; if (ex == 160) begin ex = 0; ey++; end
        end else if (plots < 19216) begin
          k = plots - 19200;
          if ({vgaX, vgaY, vgaColor} !== {8'(k + 1), 7'(k + 2), 3'((k % 7) + 1)}) begin
            bad++;
            $display("FAIL ovf_pix[%0d] got %0d,%0d,%0d want %0d,%0d,%0d", k, vgaX, vgaY, vgaColor,
                     k + 1, k + 2, (k % 7) + 1);
          end
        end else begin
          bad++;
        end
        plots++;
      end
    end
    checks++; if (plots != 19216) begin errors++; $display("FAIL ovf_plots got %0d want 19216", plots); end
    checks++; if (bad != 0) begin errors++; $display("FAIL ovf_order got %0d bad want 0", bad); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b want 0", full); end
    checks++; if (clearAck !== 1'b0) begin errors++; $display("FAIL ovf_ack got %b want 0", clearAck); end
  endtask

  task automatic test_reset_during_clear();
    int plots;
    plots = 0;
    clearReq = 1'b1;
    for (int cyc = 0; cyc < 700 && plots < 500; cyc++) begin
      tick();
      if (vgaPlot === 1'b1) plots++;
    end
    checks++; if (plots != 500) begin errors++; $display("FAIL rdc_reach got %0d want 500", plots); end
    resetIn = 1'b0; clearReq = 1'b0;
    tick();
    checks++; if (vgaPlot !== 1'b0) begin errors++; $display("FAIL rdc_plot got %b want 0", vgaPlot); end
    checks++; if (clearAck !== 1'b0) begin errors++; $display("FAIL rdc_ack got %b want 0", clearAck); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rdc_full got %b want 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rdc_ovf got %b want 0", overflow); end
    resetIn = 1'b1;
    plots = 0;
    repeat (8) begin tick(); if (vgaPlot === 1'b1) plots++; end
    checks++; if (plots != 0) begin errors++; $display("FAIL rdc_idle got %0d plots want 0", plots); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_push();
    test_back_to_back();
    test_out_of_range();
    test_reset_flush();
`ifndef VGA_CLEAR_SCREEN_EN
    test_clear_disabled();
`else
    test_clear_sweep();
    test_overflow();
    test_reset_during_clear();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_pixel_queue.md
VGA_PIXEL_QUEUE -- requirements
Module: vga_pixel_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of FIFO entries (power of 2, ≥2).
REQ-002 SHALL have parameter X_MAX, default 159, largest legal x coordinate.
REQ-003 SHALL have parameter Y_MAX, default 119, largest legal y coordinate.
REQ-004 SHALL have parameter CLEAR_COLOR, default 3'b000, fill colour for screen clear.
REQ-005 SHALL have port CLOCK_50 input 1: sole clock; all state changes on its rising edge.
REQ-006 SHALL have port resetIn input 1: synchronous, active-low reset (0 = reset).
REQ-007 SHALL have port pixWrite input 1: push strobe from drawing engines, one pixel per high cycle.
REQ-008 SHALL have port pixX input 8: pixel x.
REQ-009 SHALL have port pixY input 7: pixel y.
REQ-010 SHALL have port pixColor input 3: pixel colour.
REQ-011 SHALL have port full output 1: high when count == DEPTH.
REQ-012 SHALL have port overflow output 1: sticky flag, high after any dropped push.
REQ-013 SHALL have port clearReq input 1: screen-clear request, 4-phase handshake.
REQ-014 SHALL have port clearAck output 1: clear acknowledge.
REQ-015 SHALL have ports vgaX output 8, vgaY output 7, vgaColor output 3, vgaPlot output 1: registered drive to the VGA adapter.

Function
REQ-016 SHALL store each accepted pixel as an 18-bit entry {x,y,color} in a FIFO, in arrival order.
REQ-017 SHALL accept a push when pixWrite=1, pixX≤X_MAX, pixY≤Y_MAX, and either count<DEPTH or a pop occurs in the same cycle.
REQ-018 SHALL silently discard out-of-range pushes; overflow SHALL NOT be set for them.
REQ-019 SHALL discard an in-range push while full with no same-cycle pop, and SHALL set overflow.
REQ-020 SHALL pop one entry per cycle whenever count>0 and state is IDLE or ACK.
REQ-021 SHALL register each popped entry onto vgaX/vgaY/vgaColor with vgaPlot=1 on the next edge; vgaPlot=0 on cycles with no pop or clear write.
REQ-022 SHALL give 2-edge latency: a pixel pushed at edge N into an empty IDLE queue is popped at edge N+1 and drives vgaPlot high after edge N+2.
REQ-023 SHALL implement states IDLE, CLEAR, ACK.
REQ-024 SHALL move IDLE→CLEAR when clearReq=1 and count=0; with count>0, pops continue and CLEAR begins after the queue drains.
REQ-025 SHALL in CLEAR emit one write per cycle at CLEAR_COLOR, x-major raster from (0,0): x increments first, wraps X_MAX→0 with y+1; CLEAR SHALL last exactly (X_MAX+1)*(Y_MAX+1) write cycles.
REQ-026 SHALL go CLEAR→ACK after the write to (X_MAX,Y_MAX); in CLEAR no pops occur, but pushes are still accepted per REQ-017.
REQ-027 SHALL hold clearAck=1 in ACK only; ACK→IDLE when clearReq=0.
REQ-028 SHALL ignore deassertion of clearReq during CLEAR; the sweep completes.
REQ-029 SHALL update count by +1 for push only, −1 for pop only, and leave it unchanged for push and pop together; pointers SHALL wrap modulo DEPTH.

Reset
REQ-030 SHALL, on resetIn=0 at a rising edge, set state IDLE, count/pointers 0, clear counters 0, and full, overflow, clearAck, vgaPlot, vgaX, vgaY, vgaColor all 0.
REQ-031 SHALL abort a clear in progress on reset, and SHALL discard FIFO contents.

Configuration
REQ-032 SHALL, with macro VGA_CLEAR_SCREEN_EN defined, include the CLEAR/ACK logic per REQ-023–028.
REQ-033 SHALL, without VGA_CLEAR_SCREEN_EN, remain permanently IDLE, tie clearAck to clearReq, ignore clearReq otherwise, and remove the clear counters.

Structure
REQ-034 SHALL place the state encoding (IDLE/CLEAR/ACK) and the 18-bit entry field widths in shared package vga_pkg.
REQ-035 SHALL implement storage in one sub-module, pixel_fifo, holding the storage array, pointers, count and full/empty; the parent holds the state machine, range check and output register.

Verification
REQ-036 SHALL be checked by: push (10,20,3'b101) into an empty IDLE queue → vgaPlot=1 with (10,20,5) two edges later, exactly one cycle.
REQ-037 SHALL be checked by: 17 consecutive in-range pushes while a clear holds pops off → first 16 stored, 17th dropped, full=1, overflow=1; after ACK→IDLE, 16 plots out in order.
REQ-038 SHALL be checked by: push (160,0) and (0,120) → no plot, overflow stays 0.
REQ-039 SHALL be checked by: clearReq high from IDLE with empty queue → 19200 consecutive vgaPlot cycles, first (0,0) and last (159,119), then clearAck=1 until clearReq drops.
REQ-040 SHALL be checked by: resetIn low at sweep write 500 → next cycle vgaPlot=0, clearAck=0, state IDLE, full=0.
REQ-041 SHALL be checked by: with VGA_CLEAR_SCREEN_EN undefined, clearReq pulse → clearAck follows clearReq and no clear writes occur.
